// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the pipeline stage controller and the BRAM arbiter:
//   - STAGE_* : stage controller state constants
//   - arb_state_e : arbiter FSM encoding (2-bit)
//   - req_id_e : requester identifiers used for ownership and round-robin
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Stage controller states.
  localparam logic [2:0] STAGE_IF       = 3'd0;
  localparam logic [2:0] STAGE_IF_WAIT  = 3'd1;
  localparam logic [2:0] STAGE_ID       = 3'd2;
  localparam logic [2:0] STAGE_EX       = 3'd3;
  localparam logic [2:0] STAGE_MEM      = 3'd4;
  localparam logic [2:0] STAGE_MEM_WAIT = 3'd5;
  localparam logic [2:0] STAGE_WB       = 3'd6;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Requester identities.
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises the fetch path and the data path onto one single-port BRAM with
// round-robin fairness on simultaneous requests.
//
// Parameters:
//   ADDR_W  RAM word-address width
//   DATA_W  RAM data width
//   RD_LAT  RAM read latency in cycles after the sampling edge (1..3)
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   i_req/i_addr            fetch request (level) and address
//   i_done/i_rdata          fetch completion pulse and registered read data
//   d_req/d_we/d_addr/d_wdata  data request (level), store flag, address, data
//   d_done/d_rdata          data completion pulse and registered load data
//   ram_en/ram_we/ram_addr/ram_wdata  registered RAM port strobes
//   ram_rdata               RAM read data
//   busy                    high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = 2;

  arb_state_e       state;
  arb_state_e       state_next;
  req_id_e          owner;
  req_id_e          last_grant;
  req_id_e          pick;
  logic             any_req;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: on a tie the requester not granted last wins.
  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    any_req = i_req | d_req;
    pick    = REQ_FETCH;
    if (i_req && d_req) begin
      pick = (last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (d_req) begin
      pick = REQ_DATA;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a requester
  // dropping or holding req during RESP can never cause a second issue.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (any_req) state_next = ARB_ISSUE;
      ARB_ISSUE: state_next = we_q ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  if (cnt == '0) state_next = ARB_RESP;
      ARB_RESP:  state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy   = (state != ARB_IDLE);
    i_done = (state == ARB_RESP) && (owner == REQ_FETCH);
    d_done = (state == ARB_RESP) && (owner == REQ_DATA);
  end

  // Datapath: grant latch, RAM strobes, latency counter and read capture.
  // ram_en/ram_we are set on the grant edge so they are high for exactly the
  // ISSUE cycle; ram_addr/ram_wdata double as the latched request.
  // NOTE: the read-data registers are plain flops (not a memory array), so
  // they take the synchronous reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner      <= REQ_FETCH;
      last_grant <= REQ_FETCH;
      we_q       <= 1'b0;
      cnt        <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner     <= pick;
            we_q      <= (pick == REQ_DATA) && d_we;
            ram_en    <= 1'b1;
            ram_we    <= (pick == REQ_DATA) && d_we;
            ram_addr  <= (pick == REQ_DATA) ? d_addr : i_addr;
            ram_wdata <= (pick == REQ_DATA) ? d_wdata : '0;
          end
        end
        ARB_ISSUE: begin
          cnt <= CNT_W'(RD_LAT - 1);
        end
        ARB_WAIT: begin
          // Counter reaches zero in the cycle the RAM output is valid.
          if (cnt == '0) begin
            if (owner == REQ_DATA) begin
              d_rdata <= ram_rdata;
            end else begin
              i_rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          last_grant <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances: a fast one (RD_LAT = 1) exercised with directed and
// randomized traffic against a transaction-level model, and a slow one
// (RD_LAT = 3) exercised with directed loads. Each instance has its own RAM
// model with the matching read pipeline.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int FAST_LAT = 1;
  localparam int SLOW_LAT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial RAM contents, shared by both RAM models and the reference memory.
  function automatic logic [31:0] init_word(input int a);
    if (a == 'h10)  return 32'h0000_0013;
    if (a == 'h200) return 32'h1234_5678;
    return 32'(a) * 32'h9E37_79B1;
  endfunction

  // ---------------------------------------------------------------- fast DUT
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_done, d_done, ram_en, ram_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(FAST_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // RAM with one cycle of read latency; junk on the bus when not reading.
  logic [DW-1:0] mem_f [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) mem_f[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_en && !ram_we) ? mem_f[ram_addr] : $urandom;
  end

  // ---------------------------------------------------------------- slow DUT
  logic          s_i_req = 1'b0, s_d_req = 1'b0;
  logic [AW-1:0] s_i_addr = '0, s_d_addr = '0;
  logic          s_i_done, s_d_done, s_ram_en, s_ram_we, s_busy;
  logic [DW-1:0] s_i_rdata, s_d_rdata, s_ram_wdata, s_ram_rdata;
  logic [AW-1:0] s_ram_addr;
  logic [DW-1:0] s_pipe [0:SLOW_LAT-1];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(SLOW_LAT)) dut_slow (
    .clk(clk), .reset_n(reset_n),
    .i_req(s_i_req), .i_addr(s_i_addr), .i_done(s_i_done), .i_rdata(s_i_rdata),
    .d_req(s_d_req), .d_we(1'b0), .d_addr(s_d_addr), .d_wdata(32'h0),
    .d_done(s_d_done), .d_rdata(s_d_rdata),
    .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_addr(s_ram_addr),
    .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata), .busy(s_busy)
  );

  logic [DW-1:0] mem_s [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (s_ram_en && s_ram_we) mem_s[s_ram_addr] <= s_ram_wdata;
    s_pipe[0] <= (s_ram_en && !s_ram_we) ? mem_s[s_ram_addr] : $urandom;
    for (int k = 1; k < SLOW_LAT; k++) s_pipe[k] <= s_pipe[k-1];
  end
  assign s_ram_rdata = s_pipe[SLOW_LAT-1];

  // ------------------------------------------------- transaction-level model
  // A transaction is counted in cycles since its grant edge: cycle 1 drives
  // the RAM, the last cycle (2 for a store, 2+RD_LAT for a read) pulses done.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_k = 0, m_len = 0;
  logic          m_owner = 1'b0;       // 1 = data requester
  logic          m_last = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_i_rdata = '0, m_d_rdata = '0;
  wire           m_pick = (i_req && d_req) ? ~m_last : d_req;

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem_f[a]   = init_word(a);
      mem_s[a]   = init_word(a);
      ref_mem[a] = init_word(a);
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_k <= 0; m_last <= 1'b0; m_i_rdata <= '0; m_d_rdata <= '0;
    end else if (m_k == 0) begin
      if (i_req || d_req) begin
        m_k     <= 1;
        m_owner <= m_pick;
        m_we    <= m_pick && d_we;
        m_addr  <= m_pick ? d_addr : i_addr;
        m_wdata <= d_wdata;
        m_len   <= (m_pick && d_we) ? 2 : 2 + FAST_LAT;
        if (m_pick && d_we) ref_mem[d_addr] <= d_wdata;
      end
    end else if (m_k == m_len) begin
      m_k    <= 0;
      m_last <= m_owner;
    end else begin
      m_k <= m_k + 1;
      if (m_k == m_len - 1 && !m_we) begin
        if (m_owner) m_d_rdata <= ref_mem[m_addr];
        else         m_i_rdata <= ref_mem[m_addr];
      end
    end
  end

  // Compare process: every cycle once out of the first reset edge.
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(busy),   32'(m_k != 0));
      check("ram_en",  32'(ram_en), 32'(m_k == 1));
      check("ram_we",  32'(ram_we), 32'(m_k == 1 && m_we));
      if (m_k == 1) check("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (m_k == 1 && m_we) check("ram_wdata", ram_wdata, m_wdata);
      check("i_done",  32'(i_done), 32'(m_k != 0 && m_k == m_len && !m_owner));
      check("d_done",  32'(d_done), 32'(m_k != 0 && m_k == m_len && m_owner));
      check("i_rdata", i_rdata, m_i_rdata);
      check("d_rdata", d_rdata, m_d_rdata);
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  // One directed transaction on the fast DUT. Cycle c is the c-th cycle after
  // the sampling edge. Observes four extra cycles after done.
  task automatic run_txn(input bit is_data, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit drop_early,
                         output int lat, output int en_cnt, output int we_cnt,
                         output logic [AW-1:0] en_addr, output logic [DW-1:0] en_wdata,
                         output int done_cnt, output int other_cnt);
    lat = 0; en_cnt = 0; we_cnt = 0; en_addr = '0; en_wdata = '0;
    done_cnt = 0; other_cnt = 0;
    @(negedge clk);
    if (is_data) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
    else begin i_addr = addr; i_req = 1'b1; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && drop_early) begin i_req = 1'b0; d_req = 1'b0; end
      if (ram_en) begin en_cnt++; en_addr = ram_addr; end
      if (ram_we) begin we_cnt++; en_wdata = ram_wdata; end
      if (is_data ? d_done : i_done) begin done_cnt++; if (lat == 0) lat = c; end
      if (is_data ? i_done : d_done) other_cnt++;
      if (lat != 0 && c == lat) begin @(posedge clk); #1; i_req = 1'b0; d_req = 1'b0; end
      if (lat != 0 && c >= lat + 4) break;
    end
  endtask

  // Directed read on the slow DUT.
  task automatic run_slow(input bit is_data, input logic [AW-1:0] addr,
                          output int lat, output int other_cnt);
    lat = 0; other_cnt = 0;
    @(negedge clk);
    if (is_data) begin s_d_addr = addr; s_d_req = 1'b1; end
    else begin s_i_addr = addr; s_i_req = 1'b1; end
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (is_data ? s_d_done : s_i_done) lat = c;
      if (is_data ? s_i_done : s_d_done) other_cnt++;
    end
    @(posedge clk); #1; s_i_req = 1'b0; s_d_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 8);
    return (r == 8) ? AW'('h10) : AW'('h100 + r);
  endfunction

  // Random requesters: random gaps, back-to-back when the gap is 0, and an
  // occasional drop of req after the grant.
  task automatic fetch_agent(input int n);
    for (int t = 0; t < n; t++) begin
      bit got = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_addr = rand_addr(); i_req = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (i_done) got = 1;
        else if (i_req && m_k != 0 && !m_owner && $urandom_range(0, 3) == 0) i_req = 1'b0;
      end
      check("fetch_completes", 32'(got), 32'd1);
      @(posedge clk); #1; i_req = 1'b0;
    end
  endtask

  task automatic data_agent(input int n);
    for (int t = 0; t < n; t++) begin
      bit got = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      d_req = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (d_done) got = 1;
        else if (d_req && m_k != 0 && m_owner && $urandom_range(0, 3) == 0) d_req = 1'b0;
      end
      check("data_completes", 32'(got), 32'd1);
      @(posedge clk); #1; d_req = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int lat, en_cnt, we_cnt, done_cnt, other_cnt, dcount, idx;
    logic [AW-1:0] en_addr;
    logic [DW-1:0] en_wdata;
    int order [4];

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_done", 32'({i_done, d_done}), 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_slow_busy", 32'(s_busy), 0);
    reset_n = 1'b1;

    // Single fetch of 0x0010.
    run_txn(0, 0, 15'h0010, 32'h0, 0, lat, en_cnt, we_cnt, en_addr, en_wdata, done_cnt, other_cnt);
    check("fetch_lat", 32'(lat), 3);
    check("fetch_en_cycles", 32'(en_cnt), 1);
    check("fetch_en_addr", 32'(en_addr), 32'h0010);
    check("fetch_rdata", i_rdata, 32'h0000_0013);
    check("fetch_no_d_done", 32'(other_cnt), 0);

    // Store then fetch back.
    run_txn(1, 1, 15'h0100, 32'hDEAD_BEEF, 0, lat, en_cnt, we_cnt, en_addr, en_wdata, done_cnt, other_cnt);
    check("store_lat", 32'(lat), 2);
    check("store_we_cycles", 32'(we_cnt), 1);
    check("store_addr", 32'(en_addr), 32'h0100);
    check("store_wdata", en_wdata, 32'hDEAD_BEEF);
    run_txn(0, 0, 15'h0100, 32'h0, 0, lat, en_cnt, we_cnt, en_addr, en_wdata, done_cnt, other_cnt);
    check("readback", i_rdata, 32'hDEAD_BEEF);

    // Load with d_req dropped during ISSUE.
    run_txn(1, 0, 15'h0200, 32'h0, 1, lat, en_cnt, we_cnt, en_addr, en_wdata, done_cnt, other_cnt);
    check("drop_lat", 32'(lat), 3);
    check("drop_done_once", 32'(done_cnt), 1);
    check("drop_rdata", d_rdata, 32'h1234_5678);
    check("drop_i_rdata_kept", i_rdata, 32'hDEAD_BEEF);

    // Both requesters held high after reset: data, fetch, data, fetch.
    pulse_reset();
    @(negedge clk);
    i_addr = 15'h0010; d_addr = 15'h0200; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    idx = 0;
    for (int c = 0; c < 80 && idx < 4; c++) begin
      @(negedge clk);
      if (i_done && d_done) check("tie_single_done", 1, 0);
      if (d_done) begin order[idx] = 1; idx++; end
      else if (i_done) begin order[idx] = 0; idx++; end
    end
    @(posedge clk); #1; i_req = 1'b0; d_req = 1'b0;
    check("tie_count", 32'(idx), 4);
    check("tie_order0_data",  32'(order[0]), 1);
    check("tie_order1_fetch", 32'(order[1]), 0);
    check("tie_order2_data",  32'(order[2]), 1);
    check("tie_order3_fetch", 32'(order[3]), 0);

    // Reset while in WAIT.
    pulse_reset();
    @(negedge clk); i_addr = 15'h0010; i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wrst_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("wrst_busy", 32'(busy), 0);
    check("wrst_ram", 32'({ram_en, ram_we}), 0);
    check("wrst_ram_addr", 32'(ram_addr), 0);
    check("wrst_ram_wdata", ram_wdata, 0);
    check("wrst_i_rdata", i_rdata, 0);
    reset_n = 1'b1; i_req = 1'b0;
    dcount = 0;
    repeat (5) begin @(negedge clk); if (i_done || d_done) dcount++; end
    check("wrst_no_done", 32'(dcount), 0);
    run_txn(0, 0, 15'h0010, 32'h0, 0, lat, en_cnt, we_cnt, en_addr, en_wdata, done_cnt, other_cnt);
    check("wrst_after_lat", 32'(lat), 3);
    check("wrst_after_rdata", i_rdata, 32'h0000_0013);

    // Randomized concurrent traffic against the model.
    fork
      fetch_agent(80);
      data_agent(80);
    join
    repeat (4) @(negedge clk);

    // Slow RAM: fetch to set i_rdata, then a load of 0x0200.
    run_slow(0, 15'h0010, lat, other_cnt);
    check("slow_fetch_lat", 32'(lat), 5);
    check("slow_fetch_rdata", s_i_rdata, 32'h0000_0013);
    run_slow(1, 15'h0200, lat, other_cnt);
    check("slow_load_lat", 32'(lat), 5);
    check("slow_load_rdata", s_d_rdata, 32'h1234_5678);
    check("slow_i_rdata_kept", s_i_rdata, 32'h0000_0013);
    check("slow_no_i_done", 32'(other_cnt), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
